// File: rtl/sklansky_mp_seq.sv
// Multi-precision add sequencer: streams WORDS 16-bit words LSW-first through one Sklansky adder.
// Optional subtraction support is compiled in with `define SKL_MP_SUB_EN.

module sklansky (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] p0;

    // In-place Sklansky tree: the partner bit j always has bit l clear,
    // so it is never overwritten in the level that reads it.
    always_comb begin
        p0 = A ^ B;
        p  = p0;
        g  = A & B;
        g[0] = (A[0] & B[0]) | (p0[0] & Cin);
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i >> l) & 1) == 1) begin
                    g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
                    p[i] = p[i] & p[((i >> l) << l) - 1];
                end
            end
        end
        S[0] = p0[0] ^ Cin;
        for (int i = 1; i < 16; i++) begin
            S[i] = p0[i] ^ g[i-1];
        end
        Cout = g[15];
    end
endmodule

module sklansky_mp_seq #(
    parameter int WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [16*WORDS-1:0] A,
    input  logic [16*WORDS-1:0] B,
    input  logic              Cin,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*WORDS-1:0] S,
    output logic              Cout,
    output logic              Zero,
    output logic              Ovf,
    output logic              busy
);
    localparam int W  = 16 * WORDS;
    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic          carry_q;
    logic [W-1:0]  a_q, b_q, shadow_q, s_q;
    logic          cout_q, zero_q, ovf_q, out_valid_q;

    logic [W-1:0]  b_in;
    logic          cin_in;
    logic [W-1:0]  shadow_d;
    logic [15:0]   add_s;
    logic          add_cout;

`ifdef SKL_MP_SUB_EN
    assign b_in   = op_sub ? ~B : B;
    assign cin_in = op_sub ? 1'b1 : Cin;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_in   = B;
    assign cin_in = Cin;
`endif

    sklansky u_add (
        .A    (a_q[16*k_q +: 16]),
        .B    (b_q[16*k_q +: 16]),
        .Cin  (carry_q),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_comb begin
        shadow_d = shadow_q;
        shadow_d[16*k_q +: 16] = add_s;
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            shadow_q    <= '0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= b_in;
                        carry_q <= cin_in;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    shadow_q <= shadow_d;
                    carry_q  <= add_cout;
                    k_q      <= k_q + KW'(1);
                    if (k_q == K_LAST) begin
                        s_q         <= shadow_d;
                        cout_q      <= add_cout;
                        zero_q      <= ~|shadow_d;
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (add_s[15] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        k_q         <= '0;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;
endmodule
